// File: rtl/backend_types.sv
// Shared backend issue types: issue packet layout, branch-mask width and the
// cmp arbiter performance counter struct.
package backend_types;

  localparam int BR_MASK_W = 4;
  localparam int BR_TAG_W  = $clog2(BR_MASK_W);

  typedef enum logic [1:0] {
    CMP_EQ  = 2'd0,
    CMP_LT  = 2'd1,
    CMP_LTU = 2'd2,
    CMP_NE  = 2'd3
  } cmp_op_t;

  typedef struct packed {
    logic [BR_MASK_W-1:0] branch_mask;
    logic [5:0]           rob_idx;
  } issue_meta_t;

  typedef struct packed {
    issue_meta_t meta;
    cmp_op_t     op;
    logic [5:0]  dst;
  } issue_stage_t;

  typedef struct packed {
    logic [31:0] grants;
    logic [31:0] conflicts;
  } cmp_arb_perf_t;

endpackage

// File: rtl/brb_itf.sv
// Branch resolution bus: a resolved branch tag is broadcast as either clean
// (speculation correct) or kill (squash dependents).
interface brb_itf;
  import backend_types::*;

  logic                broadcast;
  logic [BR_TAG_W-1:0] tag;
  logic                clean;
  logic                kill;

  modport req (input broadcast, tag, clean, kill);
  modport drv (output broadcast, tag, clean, kill);
endinterface

// File: rtl/cmp_issue_arb_rr_pick.sv
// Round-robin priority pick: first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      cand = sum[PTR_W-1:0];
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cmp_issue_arb.sv
// Round-robin issue arbiter feeding one cmp unit through a single output register.
// Optional perf counters are built only when CMP_ISSUE_ARB_PERF_EN is defined.
module cmp_issue_arb
  import backend_types::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  brb_itf.req                            brif,
  input  logic         [NUM_REQ-1:0]     req_valid,
  output logic         [NUM_REQ-1:0]     req_ready,
  input  issue_stage_t [NUM_REQ-1:0]     req_stage,
  input  logic         [NUM_REQ-1:0][31:0] req_a,
  input  logic         [NUM_REQ-1:0][31:0] req_b,
  output issue_stage_t                   ostage,
  output logic         [31:0]            oa,
  output logic         [31:0]            ob,
  output logic                           ovalid,
  input  logic                           oready,
  output logic         [31:0]            perf_grants,
  output logic         [31:0]            perf_conflicts
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ-1);

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   rr_ptr;
  logic               load_en;
  logic               hs;
  logic               in_hit;
  logic               in_kill;
  logic               held_hit;
  issue_stage_t       in_stage;

  rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (idx)
  );

  assign load_en   = ~ovalid | oready;
  assign hs        = load_en & (|grant) & ~rst;
  assign req_ready = hs ? grant : '0;
  assign held_hit  = brif.broadcast & ostage.meta.branch_mask[brif.tag];

  // A branch resolving in the same cycle must also reach the packet being latched.
  always_comb begin
    in_stage = req_stage[idx];
    in_hit   = brif.broadcast & req_stage[idx].meta.branch_mask[brif.tag];
    in_kill  = in_hit & ~brif.clean & brif.kill;
    if (in_hit && brif.clean) in_stage.meta.branch_mask[brif.tag] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      rr_ptr <= '0;
    end else if (load_en) begin
      if (hs) begin
        ostage <= in_stage;
        oa     <= req_a[idx];
        ob     <= req_b[idx];
        ovalid <= ~in_kill;
        rr_ptr <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        ovalid <= 1'b0;
      end
    end else if (held_hit) begin
      if (brif.clean) ostage.meta.branch_mask[brif.tag] <= 1'b0;
      else if (brif.kill) ovalid <= 1'b0;
    end
  end

`ifdef CMP_ISSUE_ARB_PERF_EN
  cmp_arb_perf_t perf;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf <= '0;
    end else begin
      if (hs) perf.grants <= perf.grants + 32'd1;
      if ($countones(req_valid) >= 2) perf.conflicts <= perf.conflicts + 32'd1;
    end
  end

  assign perf_grants    = perf.grants;
  assign perf_conflicts = perf.conflicts;
`else
  assign perf_grants    = '0;
  assign perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_cmp_issue_arb.sv
// Self-checking bench for cmp_issue_arb: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_cmp_issue_arb;
  import backend_types::*;

  localparam int N = 2;
`ifdef CMP_ISSUE_ARB_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic         [N-1:0]      req_valid;
  logic         [N-1:0]      req_ready;
  issue_stage_t [N-1:0]      req_stage;
  logic         [N-1:0][31:0] req_a;
  logic         [N-1:0][31:0] req_b;
  issue_stage_t              ostage;
  logic         [31:0]       oa;
  logic         [31:0]       ob;
  logic                      ovalid;
  logic                      oready;
  logic         [31:0]       perf_grants;
  logic         [31:0]       perf_conflicts;

  brb_itf brif ();

  cmp_issue_arb #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .brif           (brif),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_stage      (req_stage),
    .req_a          (req_a),
    .req_b          (req_b),
    .ostage         (ostage),
    .oa             (oa),
    .ob             (ob),
    .ovalid         (ovalid),
    .oready         (oready),
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // behavioural model state
  bit           m_ovalid;
  issue_stage_t m_stage;
  logic [31:0]  m_a, m_b;
  int           m_ptr;
  int unsigned  m_grants, m_conf;
  int           last_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_valid(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock cycle: check outputs against the model, advance the model, cross the edge.
  task automatic cyc();
    bit            load;
    int            g;
    logic [N-1:0]  exp_ready;
    #2;
    load = !m_ovalid || oready;
    g    = first_valid(req_valid, m_ptr);
    exp_ready = '0;
    if (!rst && load && g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("ovalid", 32'(ovalid), 32'(m_ovalid));
    if (m_ovalid) begin
      chk("ostage", 32'(ostage), 32'(m_stage));
      chk("oa", oa, m_a);
      chk("ob", ob, m_b);
    end
    chk("rr_ptr", 32'(dut.rr_ptr), 32'(m_ptr));
    chk("perf_grants", perf_grants, PERF_EN ? m_grants : 32'd0);
    chk("perf_conflicts", perf_conflicts, PERF_EN ? m_conf : 32'd0);
    last_g = (exp_ready != 0) ? g : -1;
    if (rst) begin
      m_ovalid = 0; m_ptr = 0; m_grants = 0; m_conf = 0;
    end else begin
      if ($countones(req_valid) >= 2) m_conf++;
      if (load) begin
        if (g >= 0) begin
          m_stage = req_stage[g]; m_a = req_a[g]; m_b = req_b[g];
          m_ovalid = 1; m_ptr = (g + 1) % N; m_grants++;
        end else m_ovalid = 0;
      end
      // same resolution rule for a freshly latched or a held packet
      if (m_ovalid && brif.broadcast && m_stage.meta.branch_mask[brif.tag]) begin
        if (brif.clean) m_stage.meta.branch_mask[brif.tag] = 1'b0;
        else if (brif.kill) m_ovalid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic [BR_MASK_W-1:0] mask, input logic [31:0] a);
    req_stage[i].meta.branch_mask = mask;
    req_stage[i].meta.rob_idx     = 6'(a);
    req_stage[i].op               = cmp_op_t'(2'(i));
    req_stage[i].dst              = 6'(a + 3);
    req_a[i] = a;
    req_b[i] = ~a;
  endtask

  task automatic bus(input logic bc, input int tag, input logic cl, input logic kl);
    brif.broadcast = bc;
    brif.tag       = BR_TAG_W'(tag);
    brif.clean     = cl;
    brif.kill      = kl;
  endtask

  initial begin
    rst = 1'b1; oready = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) set_pkt(i, '0, 32'(i));
    bus(0, 0, 0, 0);
    m_ovalid = 0; m_ptr = 0; m_grants = 0; m_conf = 0; m_a = '0; m_b = '0; m_stage = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;

    // two-way contention with the consumer always ready
    req_valid = 2'b11; oready = 1'b1;
    set_pkt(0, '0, 32'h100); set_pkt(1, '0, 32'h101);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("rr_seq", 32'(last_g), 32'(c % 2));
      chk("rr_ovalid", 32'(ovalid), 32'd1);
      chk("rr_oa", oa, 32'h100 + 32'(c % 2));
    end
    req_valid = '0;
    cyc();
    chk("conflicts4", perf_conflicts, PERF_EN ? 32'd4 : 32'd0);

    // back-pressure: held packet is stable, then replaced with no bubble
    oready = 1'b0; req_valid = 2'b01; set_pkt(0, '0, 32'hA0);
    cyc();
    set_pkt(0, 4'b0010, 32'hA1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("hold_oa", oa, 32'hA0);
      chk("hold_ovalid", 32'(ovalid), 32'd1);
    end
    oready = 1'b1;
    cyc();
    chk("nobubble_oa", oa, 32'hA1);
    chk("nobubble_ovalid", 32'(ovalid), 32'd1);

    // kill on the held packet
    req_valid = '0; oready = 1'b0; bus(1, 1, 0, 1);
    cyc();
    chk("kill_ovalid", 32'(ovalid), 32'd0);
    chk("kill_ptr", 32'(dut.rr_ptr), 32'd1);
    bus(0, 0, 0, 0);

    // clean on the incoming packet
    req_valid = 2'b10; oready = 1'b1; set_pkt(1, 4'b0100, 32'hB1); bus(1, 2, 1, 0);
    cyc();
    chk("clean_ovalid", 32'(ovalid), 32'd1);
    chk("clean_mask", 32'(ostage.meta.branch_mask), 32'd0);
    bus(0, 0, 0, 0);

    // reset while holding
    rst = 1'b1; req_valid = 2'b01; oready = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    cyc();
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_ptr", 32'(dut.rr_ptr), 32'd0);
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = N'($urandom);
      oready    = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) set_pkt(i, BR_MASK_W'($urandom), $urandom);
      bus(($urandom_range(0, 3) == 0), int'($urandom_range(0, BR_MASK_W-1)),
          1'($urandom), 1'($urandom));
      cyc();
    end
    rst = 1'b0; bus(0, 0, 0, 0);

    // ten straight grants; counters follow the build option
    req_valid = 2'b01; oready = 1'b1;
    cyc();
    cyc();
    req_valid = 2'b01;
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int c = 0; c < 10; c++) cyc();
    req_valid = '0;
    cyc();
    chk("grants10", perf_grants, PERF_EN ? 32'd10 : 32'd0);
    chk("conflicts0", perf_conflicts, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmp_issue_arb.md
CMP_ISSUE_ARB -- requirements
Module: cmp_issue_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of reservation-station requesters sharing one cmp unit (legal range 2..8).
REQ-002 SHALL have parameter PTR_W, default $clog2(NUM_REQ), round-robin pointer width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port brif  brb_itf.req  --  branch bus: broadcast, tag, clean, kill.
REQ-006 SHALL have ports req_valid / req_ready  input / output  NUM_REQ  per-requester valid/ready handshake.
REQ-007 SHALL have port req_stage  input  NUM_REQ x issue_stage_t  per-requester issue packet.
REQ-008 SHALL have ports req_a, req_b  input  NUM_REQ x 32  per-requester operands.
REQ-009 SHALL have ports ostage, oa, ob  output  issue_stage_t, 32, 32  registered packet and operands to cmp (istage, cmp_a, cmp_b).
REQ-010 SHALL have ports ovalid / oready  output / input  1  handshake to cmp (ivalid / iready).
REQ-011 SHALL have ports perf_grants, perf_conflicts  output  32 each  performance counters.

Function
REQ-012 SHALL hold one output register (ostage/oa/ob/ovalid); load_en = ~ovalid | oready.
REQ-013 SHALL grant, combinationally, the first valid requester at or after rr_ptr in index order, wrapping from NUM_REQ-1 to 0.
REQ-014 SHALL assert req_ready[i] only for the granted index, and only when load_en=1; all other ready bits 0.
REQ-015 SHALL latch the granted packet and operands on handshake; ovalid rises the next cycle (1-cycle latency).
REQ-016 SHALL set rr_ptr to (granted index + 1) mod NUM_REQ on each handshake; rr_ptr SHALL be unchanged otherwise.
REQ-017 SHALL, when load_en=1 and no requester is valid, load ovalid=0.
REQ-018 SHALL hold ostage/oa/ob/ovalid stable while ovalid=1 and oready=0.
REQ-019 SHALL, on brif.broadcast with ostage.meta.branch_mask[tag]=1 while holding, clear that mask bit if clean, else clear ovalid if kill.
REQ-020 SHALL apply the same clean/kill rule to the packet being latched in the same cycle, using the incoming mask; a killed incoming packet SHALL still complete its req handshake but load ovalid=0.
REQ-021 SHALL accept a new packet in the same cycle cmp consumes the held one (oready=1, ovalid=1), with no bubble.
REQ-022 SHALL increment perf_grants per handshake and perf_conflicts per cycle with at least two req_valid bits set; both wrap modulo 2^32.

Reset
REQ-023 SHALL on rst set ovalid=0, rr_ptr=0, perf_grants=0, perf_conflicts=0; ostage/oa/ob need not reset.
REQ-024 SHALL, while rst=1, drive all req_ready bits 0 and ignore brif.

Configuration
REQ-025 SHALL compile the performance counters only when CMP_ISSUE_ARB_PERF_EN is defined; without it, perf_grants and perf_conflicts SHALL be tied to 0 with no counter flops.

Structure
REQ-026 SHALL take issue_stage_t and the branch-mask width from backend_types; a cmp_arb_perf_t counter struct SHALL be added there.
REQ-027 SHALL place the round-robin priority selection in sub-module rr_pick (inputs valid vector and pointer; outputs one-hot grant and index).

Verification
REQ-028 SHALL test: req_valid=2'b11 for 4 cycles, oready=1 -> grants 0,1,0,1; ovalid from cycle 1; perf_conflicts=4.
REQ-029 SHALL test: held packet, oready=0 for 3 cycles -> req_ready=0, ostage/oa/ob unchanged; oready=1 -> next packet loaded same cycle.
REQ-030 SHALL test: held packet mask=4'b0010, broadcast tag=1 kill=1 -> ovalid=0 next cycle, rr_ptr unchanged.
REQ-031 SHALL test: incoming packet mask=4'b0100, broadcast tag=2 clean=1 on handshake -> ovalid=1, latched mask=4'b0000.
REQ-032 SHALL test: rst asserted with ovalid=1 and req_valid=2'b01 -> ovalid=0, rr_ptr=0, req_ready=0 next cycle.
REQ-033 SHALL test: build without CMP_ISSUE_ARB_PERF_EN, 10 grants -> perf_grants=0, perf_conflicts=0.
